fetch_ctrl: RTL



---
 rtl/fetch_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and single-outstanding instruction fetch sequencer with redirect discard and one-entry output register
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        if_ready_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state;
  logic [31:0] pc_r, req_pc;
  logic        discard, slot_free, gnt_ok, resp;
  assign slot_free   = !if_valid_o || if_ready_i;
  assign ibus_req_o  = (state == REQ) && slot_free;
  assign ibus_addr_o = pc_r;
  assign gnt_ok      = ibus_req_o && ibus_gnt_i;
  assign resp        = (state == WAIT) && ibus_rvalid_i;
  // later assignments override earlier ones: load beats consume, jump beats everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_r       <= RESET_ADDR;
      req_pc     <= RESET_ADDR;
      discard    <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= 32'h0;
      if_inst_o  <= NOP_INST;
    end else begin
      if (if_valid_o && if_ready_i) begin
        if_valid_o <= 1'b0;
        if_inst_o  <= NOP_INST;
      end
      case (state)
        IDLE: state <= REQ;
        REQ: if (gnt_ok) begin
          req_pc <= pc_r;
          pc_r   <= pc_r + 32'd4;
          state  <= WAIT;
        end
        WAIT: if (ibus_rvalid_i) begin
          state <= REQ;
          if (!discard && !jump_i) begin
            if_valid_o <= 1'b1;
            if_pc_o    <= req_pc;
            if_inst_o  <= ibus_rdata_i;
          end
        end
        default: state <= IDLE;
      endcase
      discard <= resp ? 1'b0 : (discard || (jump_i && ((state == WAIT) || gnt_ok)));
      if (jump_i) begin
        pc_r       <= {jump_addr_i[31:2], 2'b00};
        if_valid_o <= 1'b0;
        if_inst_o  <= NOP_INST;
      end
    end
  end
endmodule
